// File: rtl/tsf_sync_loader.sv
// Beacon TSF adoption: drives the timer's falling-edge load port so the timer lands on remote+offset when the remote is ahead.
// Optional software absolute-load path guarded by TSF_SYNC_SW_LOAD_EN.
module tsf_sync_loader #(
  parameter int TIMER_WIDTH  = 64,
  parameter int OFFSET_WIDTH = 16,
  parameter int HOLD_CYCLES  = 2,
  parameter int MIN_DELTA    = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [TIMER_WIDTH-1:0]  tsf_runtime_val,
  input  logic                    rx_ts_valid,
  output logic                    rx_ts_ready,
  input  logic [TIMER_WIDTH-1:0]  rx_ts,
  input  logic [OFFSET_WIDTH-1:0] rx_ts_offset,
  input  logic                    sw_load_req,
  input  logic [TIMER_WIDTH-1:0]  sw_load_val,
  output logic                    tsf_load_control,
  output logic [TIMER_WIDTH-1:0]  tsf_load_val,
  output logic                    busy,
  output logic                    done,
  output logic                    done_applied,
  output logic [TIMER_WIDTH-1:0]  last_delta,
  output logic [15:0]             adjust_count
);

  typedef enum logic [1:0] {IDLE, CALC, ASSERT, LOAD} state_t;

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]       HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] MIN_D     = TIMER_WIDTH'(MIN_DELTA);

  state_t                 state;
  logic [CNT_W-1:0]       hold_cnt;
  logic [TIMER_WIDTH-1:0] target;
  logic [TIMER_WIDTH-1:0] local_cap;
  logic [TIMER_WIDTH-1:0] delta;
  logic                   apply;
  logic                   ready_en;
  logic                   sw_win;

`ifdef TSF_SYNC_SW_LOAD_EN
  logic [TIMER_WIDTH-1:0] pending_val;
  logic                   sw_active;
  assign sw_win = sw_load_req;
`else
  assign sw_win = 1'b0;
  wire unused_sw = ^{sw_load_req, sw_load_val};
`endif

  // Negative deltas (MSB set) mean the remote is behind us and are never adopted.
  assign delta       = target - local_cap;
  assign apply       = !delta[TIMER_WIDTH-1] && (delta >= MIN_D);
  // ready_en keeps ready low while in reset and for the first cycle after release.
  assign rx_ts_ready = ready_en && (state == IDLE) && !sw_win;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= IDLE;
      hold_cnt         <= '0;
      target           <= '0;
      local_cap        <= '0;
      ready_en         <= 1'b0;
      tsf_load_control <= 1'b0;
      tsf_load_val     <= '0;
      done             <= 1'b0;
      done_applied     <= 1'b0;
      last_delta       <= '0;
      adjust_count     <= '0;
`ifdef TSF_SYNC_SW_LOAD_EN
      pending_val      <= '0;
      sw_active        <= 1'b0;
`endif
    end else begin
      ready_en     <= 1'b1;
      done         <= 1'b0;
      done_applied <= 1'b0;
      case (state)
        IDLE: begin
`ifdef TSF_SYNC_SW_LOAD_EN
          if (sw_win && ready_en) begin
            pending_val      <= sw_load_val;
            sw_active        <= 1'b1;
            hold_cnt         <= '0;
            tsf_load_control <= 1'b1;
            state            <= ASSERT;
          end else
`endif
          if (rx_ts_valid && rx_ts_ready) begin
            target    <= rx_ts + TIMER_WIDTH'(rx_ts_offset);
            local_cap <= tsf_runtime_val;
            state     <= CALC;
          end
        end
        CALC: begin
          last_delta <= delta;
          if (apply) begin
            hold_cnt         <= '0;
            tsf_load_control <= 1'b1;
            state            <= ASSERT;
          end else begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        ASSERT: begin
          if (hold_cnt == HOLD_LAST) begin
            tsf_load_control <= 1'b0;
            state            <= LOAD;
            // +2 covers this cycle and the LOAD cycle before the timer takes the value.
`ifdef TSF_SYNC_SW_LOAD_EN
            tsf_load_val <= sw_active ? pending_val
                                      : tsf_runtime_val + TIMER_WIDTH'(2) + last_delta;
`else
            tsf_load_val <= tsf_runtime_val + TIMER_WIDTH'(2) + last_delta;
`endif
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        LOAD: begin
          done         <= 1'b1;
          done_applied <= 1'b1;
          if (adjust_count != 16'hFFFF) adjust_count <= adjust_count + 16'd1;
`ifdef TSF_SYNC_SW_LOAD_EN
          sw_active <= 1'b0;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tsf_sync_loader.sv
// Directed bench for tsf_sync_loader with a falling-edge-load TSF timer model.
// Expectations follow TSF_SYNC_SW_LOAD_EN when the macro is defined for the build.
module tb_tsf_sync_loader;
  localparam int W = 64;

  logic          clk = 1'b0;
  logic          rstn;
  logic [W-1:0]  tsf;
  logic          rx_ts_valid, rx_ts_ready, sw_load_req;
  logic [W-1:0]  rx_ts, sw_load_val, tsf_load_val, last_delta;
  logic [15:0]   rx_ts_offset, adjust_count;
  logic          tsf_load_control, busy, done, done_applied;
  logic          prev_ctrl, set_req;
  logic [W-1:0]  set_val;
  int            n_chk = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  tsf_sync_loader #(.TIMER_WIDTH(W), .OFFSET_WIDTH(16), .HOLD_CYCLES(2), .MIN_DELTA(1)) dut (
    .clk(clk), .rstn(rstn), .tsf_runtime_val(tsf),
    .rx_ts_valid(rx_ts_valid), .rx_ts_ready(rx_ts_ready), .rx_ts(rx_ts), .rx_ts_offset(rx_ts_offset),
    .sw_load_req(sw_load_req), .sw_load_val(sw_load_val),
    .tsf_load_control(tsf_load_control), .tsf_load_val(tsf_load_val),
    .busy(busy), .done(done), .done_applied(done_applied),
    .last_delta(last_delta), .adjust_count(adjust_count));

  // Timer model: free-running, loads on the first low cycle after a high, plus a bench preset port.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tsf       <= '0;
      prev_ctrl <= 1'b0;
    end else begin
      prev_ctrl <= tsf_load_control;
      if (set_req)                             tsf <= set_val;
      else if (prev_ctrl && !tsf_load_control) tsf <= tsf_load_val;
      else                                     tsf <= tsf + 64'd1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_tsf(input logic [63:0] v);
    @(negedge clk);
    set_req = 1'b1;
    set_val = v;
    @(negedge clk);
    set_req = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"},    64'(tsf_load_control), 64'd0);
    check({tag, "_loadval"}, tsf_load_val, 64'd0);
    check({tag, "_busy"},    64'(busy), 64'd0);
    check({tag, "_done"},    64'(done), 64'd0);
    check({tag, "_applied"}, 64'(done_applied), 64'd0);
    check({tag, "_delta"},   last_delta, 64'd0);
    check({tag, "_count"},   64'(adjust_count), 64'd0);
    check({tag, "_ready"},   64'(rx_ts_ready), 64'd0);
  endtask

  // Accept at cycle k with remote target below/equal local; expect rejection at k+2.
  task automatic reject_case(input string tag, input logic [63:0] loc, input logic [63:0] ts,
                             input logic [15:0] off, input logic [63:0] exp_delta,
                             input logic [15:0] exp_count);
    set_tsf(loc);
    rx_ts_valid = 1'b1; rx_ts = ts; rx_ts_offset = off;
    #1;
    check({tag, "_ready"}, 64'(rx_ts_ready), 64'd1);
    next_cycle();
    rx_ts_valid = 1'b0;
    check({tag, "_calc_ctrl"}, 64'(tsf_load_control), 64'd0);
    next_cycle();
    check({tag, "_done"},    64'(done), 64'd1);
    check({tag, "_applied"}, 64'(done_applied), 64'd0);
    check({tag, "_ctrl"},    64'(tsf_load_control), 64'd0);
    check({tag, "_delta"},   last_delta, exp_delta);
    check({tag, "_ready"},   64'(rx_ts_ready), 64'd1);
    check({tag, "_count"},   64'(adjust_count), 64'(exp_count));
    check({tag, "_tsf"},     tsf, loc + 64'd2);
  endtask

  // Accept at k with local=loc; expect control at k+2,k+3, LOAD at k+4, done at k+5.
  task automatic apply_case(input string tag, input logic [63:0] loc, input logic [63:0] ts,
                            input logic [15:0] off, input logic [63:0] exp_delta,
                            input logic [63:0] exp_final, input logic [15:0] exp_count);
    set_tsf(loc);
    rx_ts_valid = 1'b1; rx_ts = ts; rx_ts_offset = off;
    #1;
    check({tag, "_ready"}, 64'(rx_ts_ready), 64'd1);
    next_cycle();
    rx_ts_valid = 1'b0;
    check({tag, "_calc_busy"}, 64'(busy), 64'd1);
    check({tag, "_calc_ctrl"}, 64'(tsf_load_control), 64'd0);
    next_cycle();
    check({tag, "_ctrl_hi1"}, 64'(tsf_load_control), 64'd1);
    check({tag, "_delta"},    last_delta, exp_delta);
    next_cycle();
    check({tag, "_ctrl_hi2"}, 64'(tsf_load_control), 64'd1);
    next_cycle();
    check({tag, "_load_ctrl"}, 64'(tsf_load_control), 64'd0);
    check({tag, "_loadval"},   tsf_load_val, exp_final);
    check({tag, "_load_rdy"},  64'(rx_ts_ready), 64'd0);
    next_cycle();
    check({tag, "_done"},    64'(done), 64'd1);
    check({tag, "_applied"}, 64'(done_applied), 64'd1);
    check({tag, "_count"},   64'(adjust_count), 64'(exp_count));
    check({tag, "_tsf"},     tsf, exp_final);
    check({tag, "_ready"},   64'(rx_ts_ready), 64'd1);
    check({tag, "_busy"},    64'(busy), 64'd0);
    next_cycle();
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    rstn = 1'b1;
    rx_ts_valid = 1'b0; rx_ts = '0; rx_ts_offset = '0;
    sw_load_req = 1'b0; sw_load_val = '0;
    set_req = 1'b0; set_val = '0;
    #1 rstn = 1'b0;
    #2;
    check_reset_outputs("rst0");
    @(negedge clk);
    rstn = 1'b1;
    next_cycle();
    check("rst0_rel_ready", 64'(rx_ts_ready), 64'd1);
    check("rst0_rel_busy",  64'(busy), 64'd0);

    // 1000+20 vs local 900: delta 120, final = 900+5+120
    apply_case("adv", 64'd900, 64'd1000, 16'd20, 64'd120, 64'd1025, 16'd1);
    reject_case("behind", 64'd900, 64'd890, 16'd5, 64'hFFFF_FFFF_FFFF_FFFB, 16'd1);
    reject_case("zero", 64'd900, 64'd900, 16'd0, 64'd0, 16'd1);
    // local -16, target 0x10: delta 0x20, final = -16+5+0x20 = 0x15
    apply_case("wrap", 64'hFFFF_FFFF_FFFF_FFF0, 64'h8, 16'd8, 64'h20, 64'h15, 16'd2);

    // Software and RX requests arrive together.
    set_tsf(64'd900);
    sw_load_req = 1'b1; sw_load_val = 64'h1234;
    rx_ts_valid = 1'b1; rx_ts = 64'h2000; rx_ts_offset = 16'd0;
    #1;
`ifdef TSF_SYNC_SW_LOAD_EN
    check("sw_ready_low", 64'(rx_ts_ready), 64'd0);
    next_cycle();
    sw_load_req = 1'b0;
    check("sw_ctrl_hi1", 64'(tsf_load_control), 64'd1);
    check("sw_ready_busy", 64'(rx_ts_ready), 64'd0);
    next_cycle();
    check("sw_ctrl_hi2", 64'(tsf_load_control), 64'd1);
    next_cycle();
    check("sw_load_ctrl", 64'(tsf_load_control), 64'd0);
    check("sw_loadval", tsf_load_val, 64'h1234);
    next_cycle();
    check("sw_tsf", tsf, 64'h1234);
    check("sw_done", 64'(done_applied), 64'd1);
    check("sw_rx_accept", 64'(rx_ts_ready), 64'd1);
    check("sw_count", 64'(adjust_count), 64'd3);
    check("sw_delta_kept", last_delta, 64'h20);
    next_cycle();
    rx_ts_valid = 1'b0;
    check("swrx_calc_busy", 64'(busy), 64'd1);
    next_cycle();
    check("swrx_delta", last_delta, 64'hDCC);
    repeat (3) next_cycle();
    check("swrx_done", 64'(done_applied), 64'd1);
    check("swrx_tsf", tsf, 64'h2005);
    check("swrx_count", 64'(adjust_count), 64'd4);
`else
    check("nosw_ready", 64'(rx_ts_ready), 64'd1);
    next_cycle();
    sw_load_req = 1'b0;
    rx_ts_valid = 1'b0;
    check("nosw_calc_busy", 64'(busy), 64'd1);
    check("nosw_calc_ctrl", 64'(tsf_load_control), 64'd0);
    next_cycle();
    check("nosw_delta", last_delta, 64'd7292);
    check("nosw_ctrl_hi", 64'(tsf_load_control), 64'd1);
    repeat (3) next_cycle();
    check("nosw_done", 64'(done_applied), 64'd1);
    check("nosw_tsf", tsf, 64'h2005);
    check("nosw_count", 64'(adjust_count), 64'd3);
`endif

    // Reset in the middle of ASSERT.
    set_tsf(64'd100);
    rx_ts_valid = 1'b1; rx_ts = 64'd200; rx_ts_offset = 16'd0;
    next_cycle();
    rx_ts_valid = 1'b0;
    next_cycle();
    check("mid_ctrl_hi", 64'(tsf_load_control), 64'd1);
    rstn = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rstn = 1'b1;
    next_cycle();
    check("mid_rel_ready", 64'(rx_ts_ready), 64'd1);
    check("mid_rel_busy",  64'(busy), 64'd0);
    check("mid_rel_ctrl",  64'(tsf_load_control), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tsf_sync_loader.md
# tsf_sync_loader

Drives the load port of the TSF timer: the writer for the timer's falling-edge load interface. Accepts a received beacon timestamp from the RX path, compares it with the local TSF, and adopts it only if the remote TSF is ahead (802.11 rule). To adopt it, the block drives `tsf_load_control` high then low and presents a compensated `tsf_load_val`, so the timer lands exactly on the adjusted value. Sits in xpu between the RX timestamp extractor and the TSF timer.

## Interface
- `TIMER_WIDTH`, 64: TSF width, in timer ticks (one tick per `clk`).
- `OFFSET_WIDTH`, 16: width of the RX capture-latency offset.
- `HOLD_CYCLES`, 2: cycles `tsf_load_control` is held high; must be ≥1.
- `MIN_DELTA`, 1: smallest positive delta that triggers an adjustment.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  block clock, same clock as the TSF timer
- `rstn`  in  1  asynchronous active-low reset
- `tsf_runtime_val`  in  TIMER_WIDTH  live TSF from the timer
- `rx_ts_valid`  in  1  beacon timestamp available
- `rx_ts_ready`  out  1  block can accept a timestamp
- `rx_ts`  in  TIMER_WIDTH  beacon timestamp field
- `rx_ts_offset`  in  OFFSET_WIDTH  ticks elapsed at the remote since `rx_ts` was valid; zero-extended
- `sw_load_req`  in  1  software absolute-load request, level-sampled in IDLE
- `sw_load_val`  in  TIMER_WIDTH  absolute TSF for a software load
- `tsf_load_control`  out  1  to the timer; the timer loads on the first low cycle after a high
- `tsf_load_val`  out  TIMER_WIDTH  to the timer; registered
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse when a request completes
- `done_applied`  out  1  valid with `done`; 1 = load issued
- `last_delta`  out  TIMER_WIDTH  last computed delta (modulo 2^TIMER_WIDTH)
- `adjust_count`  out  16  count of loads issued; saturates at 0xFFFF

## Operation
- States: IDLE, CALC, ASSERT, LOAD.
- `rx_ts_ready` = (state==IDLE) && !sw_win, where sw_win = `sw_load_req` && `TSF_SYNC_SW_LOAD_EN`.
- IDLE, sw_win:
  - `pending_val` <= `sw_load_val`.
  - Go to ASSERT, skipping CALC. `last_delta` is unchanged.
- IDLE, `rx_ts_valid` && `rx_ts_ready`:
  - `target` <= `rx_ts` + `rx_ts_offset` (mod 2^W).
  - `local_cap` <= `tsf_runtime_val`.
  - Go to CALC.
- CALC (one cycle):
  - delta = `target` − `local_cap` (mod 2^W); `last_delta` <= delta.
  - Apply iff delta[W-1]==0 and delta ≥ MIN_DELTA. If applied, go to ASSERT.
  - Otherwise go to IDLE with `done`=1 and `done_applied`=0 in the next cycle.
- ASSERT:
  - `tsf_load_control`=1 for exactly HOLD_CYCLES cycles.
  - On the last ASSERT cycle, `tsf_load_val` <= `tsf_runtime_val` + 2 + delta for RX requests, or `pending_val` for software requests.
- LOAD (one cycle): `tsf_load_control`=0 while `tsf_load_val` is held. The timer takes the value at the end of this cycle. Go to IDLE; `adjust_count` += 1 (saturating).
- First IDLE cycle after LOAD: `done`=1, `done_applied`=1.
- `tsf_load_val` holds its value outside ASSERT→LOAD.
- Resulting RX adjustment: after the load, the timer reads (uninterrupted count) + delta, exactly.

## Timing
- Reset (async): state IDLE; all outputs 0 (`rx_ts_ready` goes to 1 after reset release), including `tsf_load_control`, `tsf_load_val`, `busy`, `done`, `done_applied`, `last_delta`, `adjust_count`.
- RX accept at cycle k:
  - CALC at k+1.
  - ASSERT at k+2 .. k+1+HOLD_CYCLES.
  - LOAD at k+2+HOLD_CYCLES.
  - `done` at k+3+HOLD_CYCLES; `rx_ts_ready` high again in that same cycle.
- RX rejection: `done` at k+2, `rx_ts_ready` high at k+2; `tsf_load_control` never rises.
- Software request sampled at cycle k: ASSERT starts at k+1, so one cycle shorter than RX.
- Simultaneous `sw_load_req` and `rx_ts_valid`: software wins; the RX request stays pending (valid held, ready low) and is accepted at the first IDLE cycle after completion.
- Wrap-around: all sums and differences are modulo 2^TIMER_WIDTH; deltas ≥ 2^(W-1) count as negative.
- Reset mid-ASSERT: `tsf_load_control` drops to 0 asynchronously. The timer shares `rstn`, so no spurious load occurs; integrators must keep this reset shared.

## Configuration
- `TSF_SYNC_SW_LOAD_EN` defined: the software absolute-load path is active as above.
- Not defined:
  - `sw_load_req` and `sw_load_val` are ignored and the `pending_val` register is removed.
  - sw_win is constant 0, so `rx_ts_ready` = (state==IDLE).

## Test plan
- Reset asserted mid-run → all outputs 0 immediately; after release, `rx_ts_ready`=1 and `busy`=0.
- `rx_ts`=1000, `rx_ts_offset`=20, local=900 at accept, HOLD_CYCLES=2 →
  - `last_delta`=120; control high exactly 2 cycles.
  - `tsf_load_val` = R+122, where R = TSF on the last ASSERT cycle.
  - Timer is continuous +120; `done_applied`=1, `adjust_count`=1.
- `rx_ts`+offset = local−5 →
  - `last_delta`=2^64−5; control stays 0.
  - `done` at k+2 with `done_applied`=0; `adjust_count` unchanged.
- delta=0 with MIN_DELTA=1 → rejected, same response as the previous case.
- local=0xFFFF_FFFF_FFFF_FFF0, target=0x10 → delta=0x20 applied; `tsf_load_val` wraps correctly.
- Macro defined: `sw_load_req` with 0x1234, simultaneous with `rx_ts_valid` →
  - Timer reads 0x1234 after LOAD.
  - RX request accepted on the `done` cycle.
  - Macro undefined: the same stimulus processes RX only.
